// File: rtl/bcd_adjust_if.sv
// Request/result bus for the decimal-adjust stage: ALU result and adjust hints in,
// corrected byte plus flags out, each side with its own valid/ready pair.
interface bcd_adjust_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] res;
    logic       alu_c;
    logic       adj_lsd;
    logic       adj_msd;
    logic       sub;
    logic       dec;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] OUT;
    logic       C;
    logic       N;
    logic       Z;

    modport master (
        output in_valid, res, alu_c, adj_lsd, adj_msd, sub, dec, out_ready,
        input  in_ready, out_valid, OUT, C, N, Z
    );

    modport slave (
        input  in_valid, res, alu_c, adj_lsd, adj_msd, sub, dec, out_ready,
        output in_ready, out_valid, OUT, C, N, Z
    );
endinterface

// File: rtl/bcd_adjust.sv
// Decimal-adjusts an 8-bit ALU result (+/-0x06 low digit, +/-0x60 high digit).
// Latency: 1 cycle binary, 3 cycles decimal (2 with FAST); holds the result until out_ready.
module bcd_adjust #(
    parameter bit FAST = 1'b0
) (
    input  logic         clk,
    input  logic         RST_n,
    bcd_adjust_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, LSD, MSD, ADJ, DONE} state_t;

    state_t     state, state_nxt;
    logic [7:0] work;
    logic       sub_r, adj_lsd_r, adj_msd_r;
    logic [7:0] lsd_val, msd_val, adj_val;
    logic       accept, load_out, c_nxt;
    logic [7:0] out_nxt;

    function automatic logic [7:0] step(input logic [7:0] v, input logic en,
                                        input logic s, input logic [7:0] k);
        if (!en)
            return v;
        return s ? (v - k) : (v + k);
    endfunction

    assign lsd_val = step(work, adj_lsd_r, sub_r, 8'h06);
    assign msd_val = step(work, adj_msd_r, sub_r, 8'h60);
    assign adj_val = step(lsd_val, adj_msd_r, sub_r, 8'h60);

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign accept        = (state == IDLE) && bus.in_valid;

    always_comb begin
        state_nxt = state;
        load_out  = 1'b0;
        out_nxt   = work;
        c_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.dec) begin
                        state_nxt = FAST ? ADJ : LSD;
                    end else begin
                        // binary results bypass correction and go straight out
                        state_nxt = DONE;
                        load_out  = 1'b1;
                        out_nxt   = bus.res;
                        c_nxt     = bus.alu_c;
                    end
                end
            end
            LSD: state_nxt = MSD;
            MSD: begin
                state_nxt = DONE;
                load_out  = 1'b1;
                out_nxt   = msd_val;
                c_nxt     = adj_msd_r ^ sub_r;
            end
            ADJ: begin
                state_nxt = DONE;
                load_out  = 1'b1;
                out_nxt   = adj_val;
                c_nxt     = adj_msd_r ^ sub_r;
            end
            DONE: begin
                if (bus.out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            state     <= IDLE;
            work      <= 8'h00;
            sub_r     <= 1'b0;
            adj_lsd_r <= 1'b0;
            adj_msd_r <= 1'b0;
            bus.OUT   <= 8'h00;
            bus.C     <= 1'b0;
            bus.N     <= 1'b0;
            bus.Z     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                work      <= bus.res;
                sub_r     <= bus.sub;
                adj_lsd_r <= bus.adj_lsd;
                adj_msd_r <= bus.adj_msd;
            end else if (state == LSD) begin
                work <= lsd_val;
            end
            if (load_out) begin
                bus.OUT <= out_nxt;
                bus.C   <= c_nxt;
                bus.N   <= out_nxt[7];
                bus.Z   <= (out_nxt == 8'h00);
            end
        end
    end

endmodule

// File: tb/tb_bcd_adjust.sv
// Drives a FAST=0 and a FAST=1 instance side by side and checks both against a decimal-adjust model.
module tb_bcd_adjust;

    logic clk = 1'b0;
    logic RST_n;
    always #5 clk = ~clk;

    bcd_adjust_if b0();
    bcd_adjust_if b1();

    bcd_adjust #(.FAST(1'b0)) dut0 (.clk(clk), .RST_n(RST_n), .bus(b0));
    bcd_adjust #(.FAST(1'b1)) dut1 (.clk(clk), .RST_n(RST_n), .bus(b1));

    int checks   = 0;
    int failures = 0;

    function automatic logic [7:0] model_out(input logic [7:0] r, input logic l, input logic m,
                                             input logic s, input logic d);
        int v;
        v = int'(r);
        if (d) begin
            if (l) v = s ? v - 6 : v + 6;
            if (m) v = s ? v - 96 : v + 96;
        end
        return 8'(v & 255);
    endfunction

    task automatic drive(input logic v0, input logic v1, input logic [7:0] r, input logic c,
                         input logic l, input logic m, input logic s, input logic d);
        b0.in_valid = v0;  b1.in_valid = v1;
        b0.res = r;        b1.res = r;
        b0.alu_c = c;      b1.alu_c = c;
        b0.adj_lsd = l;    b1.adj_lsd = l;
        b0.adj_msd = m;    b1.adj_msd = m;
        b0.sub = s;        b1.sub = s;
        b0.dec = d;        b1.dec = d;
    endtask

    task automatic test_reset();
        RST_n = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        b0.out_ready = 1'b1;
        b1.out_ready = 1'b1;
        #12;
        checks++;
        if ({b0.out_valid, b0.OUT, b0.C, b0.N, b0.Z} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs_fast0 got ov=%b out=%h c=%b n=%b z=%b need all zero",
                     b0.out_valid, b0.OUT, b0.C, b0.N, b0.Z);
        end
        checks++;
        if ({b1.out_valid, b1.OUT, b1.C, b1.N, b1.Z} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs_fast1 got ov=%b out=%h c=%b n=%b z=%b need all zero",
                     b1.out_valid, b1.OUT, b1.C, b1.N, b1.Z);
        end
        @(negedge clk);
        RST_n = 1'b1;
        @(negedge clk);
        checks++;
        if (b0.in_ready !== 1'b1 || b1.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got %b/%b need 1/1", b0.in_ready, b1.in_ready);
        end
    endtask

    // Called at a negedge with both instances idle; returns at a negedge with both idle.
    task automatic run_txn(input logic [7:0] r, input logic c, input logic l, input logic m,
                           input logic s, input logic d);
        int         lat0, lat1, e0, e1;
        logic [7:0] o0, o1, eo;
        logic [2:0] f0, f1, ef;
        lat0 = -1; lat1 = -1; o0 = 8'h00; o1 = 8'h00; f0 = 3'b000; f1 = 3'b000;
        drive(1'b1, 1'b1, r, c, l, m, s, d);
        b0.out_ready = 1'b1;
        b1.out_ready = 1'b1;
        checks++;
        if (b0.in_ready !== 1'b1 || b1.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL txn_in_ready got %b/%b need 1/1", b0.in_ready, b1.in_ready);
        end
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (b0.out_valid === 1'b1 && lat0 < 0) begin
                lat0 = n; o0 = b0.OUT; f0 = {b0.C, b0.N, b0.Z};
            end
            if (b1.out_valid === 1'b1 && lat1 < 0) begin
                lat1 = n; o1 = b1.OUT; f1 = {b1.C, b1.N, b1.Z};
            end
            if (n == 1)
                drive(1'b0, 1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom), 1'($urandom));
        end
        eo = model_out(r, l, m, s, d);
        ef = {d ? (m ^ s) : c, eo[7], eo == 8'h00};
        e0 = d ? 3 : 1;
        e1 = d ? 2 : 1;
        checks++;
        if (lat0 != e0 || o0 !== eo || f0 !== ef) begin
            failures++;
            $display("FAIL txn_fast0 res=%h l=%b m=%b s=%b d=%b got lat=%0d out=%h cnz=%b need lat=%0d out=%h cnz=%b",
                     r, l, m, s, d, lat0, o0, f0, e0, eo, ef);
        end
        checks++;
        if (lat1 != e1 || o1 !== eo || f1 !== ef) begin
            failures++;
            $display("FAIL txn_fast1 res=%h l=%b m=%b s=%b d=%b got lat=%0d out=%h cnz=%b need lat=%0d out=%h cnz=%b",
                     r, l, m, s, d, lat1, o1, f1, e1, eo, ef);
        end
    endtask

    task automatic test_directed();
        run_txn(8'h0A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        run_txn(8'h9A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        run_txn(8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        run_txn(8'h0F, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        run_txn(8'h80, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        run_txn(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++)
            run_txn(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom_range(0, 3) != 0));
    endtask

    task automatic test_hold();
        int waited;
        drive(1'b1, 1'b0, 8'h0A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        b0.out_ready = 1'b0;
        @(negedge clk);
        drive(1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        waited = 0;
        while (b0.out_valid !== 1'b1 && waited < 6) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (waited != 2) begin
            failures++;
            $display("FAIL hold_latency got %0d extra cycles need 2", waited);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (b0.out_valid !== 1'b1 || b0.in_ready !== 1'b0 || b0.OUT !== 8'h10 ||
                {b0.C, b0.N, b0.Z} !== 3'b000) begin
                failures++;
                $display("FAIL hold_stable cycle %0d got ov=%b ir=%b out=%h cnz=%b need 1 0 10 000",
                         k, b0.out_valid, b0.in_ready, b0.OUT, {b0.C, b0.N, b0.Z});
            end
            if (k < 4) @(negedge clk);
        end
        b0.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (b0.out_valid !== 1'b0 || b0.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL hold_release got ov=%b ir=%b need 0 1", b0.out_valid, b0.in_ready);
        end
        @(negedge clk);
        checks++;
        if (b0.out_valid !== 1'b1 || b0.in_ready !== 1'b0 || b0.OUT !== 8'h55 || b0.C !== 1'b1) begin
            failures++;
            $display("FAIL hold_second_accept got ov=%b ir=%b out=%h c=%b need 1 0 55 1",
                     b0.out_valid, b0.in_ready, b0.OUT, b0.C);
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        run_txn(8'h0A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 8'h12, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1 RST_n = 1'b0;
        #1;
        checks++;
        if (b0.out_valid !== 1'b0 || b0.OUT !== 8'h00 || b1.OUT !== 8'h00) begin
            failures++;
            $display("FAIL abort_reset got ov=%b out=%h out1=%h need 0 00 00",
                     b0.out_valid, b0.OUT, b1.OUT);
        end
        #1 RST_n = 1'b1;
        @(negedge clk);
        checks++;
        if (b0.in_ready !== 1'b1 || b1.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL abort_in_ready got %b/%b need 1/1", b0.in_ready, b1.in_ready);
        end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (b0.out_valid !== 1'b0 || b0.OUT !== 8'h00) begin
                failures++;
                $display("FAIL abort_no_result cycle %0d got ov=%b out=%h need 0 00",
                         k, b0.out_valid, b0.OUT);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_hold();
        test_reset_abort();
        run_txn(8'h45, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_adjust.md
BCD_ADJUST -- requirements
Module: bcd_adjust

Interface
REQ-001 Parameter: FAST, 0, when 1 both nibble corrections are applied in a single ADJ cycle instead of separate LSD and MSD cycles.
REQ-002 Port: clk  input  1  single clock, all state on rising edge.
REQ-003 Port: RST_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: in_valid  input  1  request present on the input bus.
REQ-005 Port: in_ready  output  1  block accepts a request this cycle.
REQ-006 Port: res  input  8  raw ALU binary result.
REQ-007 Port: alu_c  input  1  ALU digital carry out.
REQ-008 Port: adj_lsd  input  1  ALU low-digit adjust request.
REQ-009 Port: adj_msd  input  1  ALU high-digit adjust request.
REQ-010 Port: sub  input  1  operation was a subtraction (the ALU inv_bi setting).
REQ-011 Port: dec  input  1  decimal mode (D flag).
REQ-012 Port: out_valid  output  1  corrected result available.
REQ-013 Port: out_ready  input  1  consumer takes the result.
REQ-014 Port: OUT  output  8  corrected result.
REQ-015 Port: C, N, Z  output  1 each  carry, negative and zero flags of OUT.

Function
REQ-016 States SHALL be IDLE, LSD, MSD and DONE; FAST=1 replaces LSD and MSD with a single ADJ state.
REQ-017 in_ready SHALL be 1 only in IDLE; a request is accepted on the edge where in_valid and in_ready are both 1.
REQ-018 On accept, the block SHALL latch res, alu_c, adj_lsd, adj_msd, sub and dec into internal registers; the inputs are don't-care afterwards.
REQ-019 Accept with dec=0: go to DONE with OUT=res and C=alu_c; out_valid is asserted the cycle after accept.
REQ-020 Accept with dec=1: IDLE->LSD->MSD->DONE (FAST=0) or IDLE->ADJ->DONE (FAST=1); out_valid is asserted 3 (FAST=0) or 2 (FAST=1) cycles after accept.
REQ-021 LSD step: if adj_lsd, the working value SHALL become value+0x06 (sub=0) or value-0x06 (sub=1), as a full 8-bit operation modulo 256; otherwise the value is unchanged.
REQ-022 MSD step: if adj_msd, the working value SHALL become value+0x60 (sub=0) or value-0x60 (sub=1), modulo 256; otherwise the value is unchanged.
REQ-023 The ADJ step SHALL equal an LSD step followed by an MSD step.
REQ-024 Both steps SHALL always consume their cycle, even when the matching adj flag is 0, so decimal latency is fixed.
REQ-025 Decimal carry SHALL be C=adj_msd when sub=0 and C=~adj_msd when sub=1.
REQ-026 N SHALL equal OUT[7] and Z SHALL equal (OUT==0), both registered with OUT.
REQ-027 OUT, C, N and Z SHALL update only on the entry to DONE, and hold stable while out_valid=1 and out_ready=0.
REQ-028 In DONE with out_ready=1: drop out_valid and go to IDLE on the next edge; a new request is never accepted in the same cycle as a result is taken.
REQ-029 out_ready is ignored outside DONE.
REQ-030 in_valid is ignored outside IDLE.

Reset
REQ-031 RST_n=0 SHALL asynchronously force state IDLE, out_valid=0, OUT=0x00, C=0, N=0, Z=0 and clear all internal registers.
REQ-032 in_ready SHALL be 1 in the first cycle after RST_n is released.
REQ-033 A reset asserted in LSD, MSD, ADJ or DONE SHALL abort the operation with no result delivered.

Verification
REQ-034 dec=1, sub=0, res=0x0A, adj_lsd=1, adj_msd=0 -> OUT=0x10, C=0, N=0, Z=0, out_valid at accept+3.
REQ-035 dec=1, sub=0, res=0x9A, adj_lsd=1, adj_msd=1 -> OUT=0x00, C=1, Z=1; repeated with FAST=1, out_valid at accept+2.
REQ-036 dec=1, sub=1, res=0xFF, adj_lsd=1, adj_msd=1 -> OUT=0x99, C=0, N=1; with res=0x0F, adj_lsd=1, adj_msd=0 -> OUT=0x09, C=1.
REQ-037 dec=0, res=0x80, alu_c=1, adj flags=1 -> OUT=0x80, C=1, N=1, out_valid at accept+1 with no correction applied.
REQ-038 Hold out_ready=0 for 5 cycles in DONE while in_valid=1 -> OUT and flags stay stable, in_ready=0 throughout, no second accept until one cycle after out_ready=1.
REQ-039 Pulse RST_n=0 during MSD -> out_valid=0 and OUT=0x00 immediately; in_ready=1 after release; the aborted result never appears.
